llc_set_buf_wb: RTL and testbench
=================================

# llc_set_buf_wb

Parametrised per-set working buffer for the LLC controller. It snapshots every way of one set (line, tag, packed metadata, dirty bit, eviction pointer) on a lookup and applies single-way updates. It also adds two features the fixed-width buffer lacked: a multi-beat memory fill engine and a dirty-way write-back drain engine. It sits between the LLC data/tag RAMs and the LLC main FSM and memory interface.

## Interface
Parameters:
- WAYS, 16, ways per set; power of 2, ≥2; WB = $clog2(WAYS)
- LINE_BITS, 128, line width
- BEAT_BITS, 64, fill beat width; divides LINE_BITS; BEATS = LINE_BITS/BEAT_BITS
- TAG_BITS, 20, tag width
- META_BITS, 24, packed state/sharers/owner/hprot width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all buffers; aborts any engine
- load  in  1  capture snapshot from rd_* inputs
- rd_line  in  WAYS*LINE_BITS  RAM line data, way i at [i*LINE_BITS +: LINE_BITS]
- rd_tag / rd_meta  in  WAYS*TAG_BITS / WAYS*META_BITS  RAM tags / metadata
- rd_dirty  in  WAYS  RAM dirty bits
- rd_evict_way  in  WB  RAM eviction pointer
- wr_way  in  WB  target way for wr_*
- wr_line_en, wr_tag_en, wr_meta_en, wr_dirty_en  in  1 each  field write enables
- wr_line, wr_tag, wr_meta, wr_dirty  in  LINE_BITS, TAG_BITS, META_BITS, 1  write data
- evict_incr  in  1  advance eviction pointer
- fill_start  in  1  start beat fill; fill_way  in  WB  target way
- fill_valid  in  1 / fill_ready  out  1 / fill_data  in  BEAT_BITS  beat handshake
- fill_done  out  1  one-cycle pulse, fill complete
- wb_start  in  1  start dirty drain
- wb_valid  out  1 / wb_ready  in  1  drain handshake; wb_way  out  WB; wb_tag  out  TAG_BITS; wb_line  out  LINE_BITS
- wb_done  out  1  one-cycle pulse, drain complete
- busy  out  1  engine not IDLE
- lines_buf, tags_buf, meta_buf  out  flattened as rd_*  buffered fields
- dirty_buf  out  WAYS; evict_way_buf  out  WB

## Operation
- FSM states IDLE, FILL, DRAIN. fill_start/wb_start are honoured only in IDLE; if both are high, fill_start wins and wb_start is dropped.
- Field update priority, per way, per cycle: clr > load > engine write > wr_*.
  - load overwrites all fields of every way.
  - wr_* writes only way wr_way.
- Eviction pointer priority: clr (→0) > load (rd_evict_way) > evict_incr (+1 mod WAYS; WAYS-1 wraps to 0).
- FILL:
  - fill_way and a beat counter (0) are latched at fill_start.
  - fill_ready=1 throughout FILL.
  - Beat k accepted (fill_valid&fill_ready) writes lines_buf[fill_way][k*BEAT_BITS +: BEAT_BITS]; other bits are untouched.
  - Beat k writes override a same-cycle wr_line to the same way; wr_line to other ways proceeds.
  - On acceptance of beat BEATS-1 → IDLE; fill_done=1 the next cycle.
  - Tag/meta/dirty are not modified by FILL.
- DRAIN:
  - wb_start with dirty_buf==0 → stay IDLE; wb_done pulses the next cycle.
  - Otherwise → DRAIN. wb_valid = (dirty_buf!=0); wb_way = lowest-index set dirty bit; wb_tag/wb_line come from that way (combinational).
  - Handshake clears dirty_buf[wb_way]. A same-cycle wr_dirty_en to that way wins (bit keeps wr_dirty and the way is redrained).
  - When dirty_buf becomes 0 → IDLE; wb_done pulses the cycle after the final handshake.
- clr or load mid-engine:
  - clr → IDLE immediately; no done pulse.
  - load does not abort. FILL continues on the new snapshot; DRAIN rescans the new dirty mask.

## Timing
- Reset (rst=1, async): every buffer 0, evict_way_buf=0, dirty_buf=0, state IDLE; fill_ready, fill_done, wb_valid, wb_done, busy all 0; wb_way/wb_tag/wb_line 0.
- load/wr_*/evict_incr visible on outputs 1 cycle after the enabling edge.
- Fill latency: fill_start edge → FILL next cycle; with fill_valid held high, BEATS beats take BEATS cycles, then fill_done at cycle BEATS+1 after the start.
- Drain: one way per cycle when wb_ready is held high; D dirty ways → wb_done at cycle D+1 after entering DRAIN.
- Combinational outputs: fill_ready, wb_valid, wb_way, wb_tag, wb_line, busy (= state≠IDLE). All others are registered.
- wb_valid may only drop via handshake, clr, or a wr_dirty/load that empties the mask; the upstream FSM must not clear dirty bits during DRAIN.

## Test plan
- Reset/load: assert rst, load way 3 tag 0x1A and evict 7 → all outputs 0 after reset; tags_buf way 3 = 0x1A and evict_way_buf = 7 one cycle after load.
- Eviction wrap: evict_way_buf = 15, evict_incr → 0; load and evict_incr together → rd_evict_way.
- Fill with backpressure: BEATS=2, fill_way=5, beats 0xAAAA… and 0x5555… with fill_valid gaps → line 5 = {0x5555…, 0xAAAA…}; fill_done pulses once; same-cycle wr_line to way 5 is overridden.
- Drain: dirty_buf = 0b1001_0000_0000_0100, wb_ready toggling → wb_way sequence 2, 12, 15; dirty bits cleared one per handshake; wb_done after the last.
- Empty drain and start conflict: wb_start with dirty 0 → wb_done next cycle, busy never 1; fill_start+wb_start together → FILL only.
- Abort: clr during FILL after 1 beat → IDLE, all buffers 0, no fill_done; async rst mid-DRAIN → immediate reset values.

Source files
------------

// File: rtl/llc_set_buf_wb.sv
// llc_set_buf_wb: per-set working buffer with snapshot load, single-way updates,
// a multi-beat line fill engine and a dirty-way write-back drain engine.
module llc_set_buf_wb #(
    parameter int WAYS      = 16,
    parameter int LINE_BITS = 128,
    parameter int BEAT_BITS = 64,
    parameter int TAG_BITS  = 20,
    parameter int META_BITS = 24,
    parameter int WB        = $clog2(WAYS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      load,
    input  logic [WAYS*LINE_BITS-1:0] rd_line,
    input  logic [WAYS*TAG_BITS-1:0]  rd_tag,
    input  logic [WAYS*META_BITS-1:0] rd_meta,
    input  logic [WAYS-1:0]           rd_dirty,
    input  logic [WB-1:0]             rd_evict_way,
    input  logic [WB-1:0]             wr_way,
    input  logic                      wr_line_en,
    input  logic                      wr_tag_en,
    input  logic                      wr_meta_en,
    input  logic                      wr_dirty_en,
    input  logic [LINE_BITS-1:0]      wr_line,
    input  logic [TAG_BITS-1:0]       wr_tag,
    input  logic [META_BITS-1:0]      wr_meta,
    input  logic                      wr_dirty,
    input  logic                      evict_incr,
    input  logic                      fill_start,
    input  logic [WB-1:0]             fill_way,
    input  logic                      fill_valid,
    output logic                      fill_ready,
    input  logic [BEAT_BITS-1:0]      fill_data,
    output logic                      fill_done,
    input  logic                      wb_start,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [WB-1:0]             wb_way,
    output logic [TAG_BITS-1:0]       wb_tag,
    output logic [LINE_BITS-1:0]      wb_line,
    output logic                      wb_done,
    output logic                      busy,
    output logic [WAYS*LINE_BITS-1:0] lines_buf,
    output logic [WAYS*TAG_BITS-1:0]  tags_buf,
    output logic [WAYS*META_BITS-1:0] meta_buf,
    output logic [WAYS-1:0]           dirty_buf,
    output logic [WB-1:0]             evict_way_buf
);
    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    state_t state, state_nx;
    logic [LINE_BITS-1:0] lines [WAYS];
    logic [TAG_BITS-1:0]  tags  [WAYS];
    logic [META_BITS-1:0] metas [WAYS];
    logic [WAYS-1:0]      dirty_nx;
    logic [WB-1:0]        fway;
    logic [CW-1:0]        beat;
    logic                 beat_acc, last_beat, wb_hs, idle_start;
    assign fill_ready = state == FILL;
    assign busy       = state != IDLE;
    assign wb_valid   = state == DRAIN && |dirty_buf;
    assign wb_tag     = wb_valid ? tags[wb_way] : '0;
    assign wb_line    = wb_valid ? lines[wb_way] : '0;
    assign beat_acc   = fill_valid && fill_ready;
    assign last_beat  = beat == CW'(BEATS - 1);
    assign wb_hs      = wb_valid && wb_ready;
    assign idle_start = state == IDLE && fill_start;
    // Lowest-index dirty way is drained first.
    always_comb begin
        wb_way = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (state == DRAIN && dirty_buf[i]) wb_way = WB'(i);
    end
    // A same-cycle wr_dirty to the drained way beats the handshake clear.
    always_comb begin
        dirty_nx = dirty_buf;
        if (wb_hs) dirty_nx[wb_way] = 1'b0;
        if (wr_dirty_en) dirty_nx[wr_way] = wr_dirty;
        if (load) dirty_nx = rd_dirty;
        if (clr) dirty_nx = '0;
    end
    always_comb begin
        state_nx = clr ? IDLE
                 : state == IDLE ? (fill_start ? FILL : (wb_start && |dirty_buf) ? DRAIN : IDLE)
                 : state == FILL ? ((beat_acc && last_beat) ? IDLE : FILL)
                 : (|dirty_nx ? DRAIN : IDLE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) begin
                lines[i] <= '0;
                tags[i]  <= '0;
                metas[i] <= '0;
            end
            dirty_buf     <= '0;
            evict_way_buf <= '0;
            fway          <= '0;
            beat          <= '0;
            fill_done     <= 1'b0;
            wb_done       <= 1'b0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (clr) begin
                    lines[i] <= '0;
                    tags[i]  <= '0;
                    metas[i] <= '0;
                end else if (load) begin
                    lines[i] <= rd_line[i*LINE_BITS +: LINE_BITS];
                    tags[i]  <= rd_tag[i*TAG_BITS +: TAG_BITS];
                    metas[i] <= rd_meta[i*META_BITS +: META_BITS];
                end else begin
                    if (beat_acc && fway == WB'(i)) lines[i][beat*BEAT_BITS +: BEAT_BITS] <= fill_data;
                    else if (wr_line_en && wr_way == WB'(i)) lines[i] <= wr_line;
                    if (wr_tag_en && wr_way == WB'(i)) tags[i] <= wr_tag;
                    if (wr_meta_en && wr_way == WB'(i)) metas[i] <= wr_meta;
                end
            end
            dirty_buf     <= dirty_nx;
            evict_way_buf <= clr ? '0 : load ? rd_evict_way : evict_incr ? evict_way_buf + WB'(1) : evict_way_buf;
            fway          <= idle_start ? fill_way : fway;
            beat          <= (clr || idle_start) ? '0 : beat_acc ? beat + CW'(1) : beat;
            fill_done     <= !clr && state == FILL && beat_acc && last_beat;
            wb_done       <= !clr && ((state == IDLE && !fill_start && wb_start && dirty_buf == '0)
                                      || (state == DRAIN && dirty_nx == '0));
        end
    end
    for (genvar g = 0; g < WAYS; g++) begin : g_pack
        assign lines_buf[g*LINE_BITS +: LINE_BITS] = lines[g];
        assign tags_buf[g*TAG_BITS +: TAG_BITS]    = tags[g];
        assign meta_buf[g*META_BITS +: META_BITS]  = metas[g];
    end
endmodule

// File: tb/tb_llc_set_buf_wb.sv
// tb_llc_set_buf_wb: directed scoreboard bench for llc_set_buf_wb.
module tb_llc_set_buf_wb;
    localparam int WAYS = 16, LB = 128, BB = 64, TB = 20, MB = 24, WB = 4;
    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, load = 1'b0;
    logic [WAYS*LB-1:0] rd_line = '0;
    logic [WAYS*TB-1:0] rd_tag = '0;
    logic [WAYS*MB-1:0] rd_meta = '0;
    logic [WAYS-1:0] rd_dirty = '0;
    logic [WB-1:0] rd_evict_way = '0, wr_way = '0, fill_way = '0;
    logic wr_line_en = 0, wr_tag_en = 0, wr_meta_en = 0, wr_dirty_en = 0, wr_dirty = 0;
    logic [LB-1:0] wr_line = '0;
    logic [TB-1:0] wr_tag = '0;
    logic [MB-1:0] wr_meta = '0;
    logic evict_incr = 0, fill_start = 0, fill_valid = 0, wb_start = 0, wb_ready = 0;
    logic [BB-1:0] fill_data = '0;
    logic fill_ready, fill_done, wb_valid, wb_done, busy;
    logic [WB-1:0] wb_way, evict_way_buf;
    logic [TB-1:0] wb_tag;
    logic [LB-1:0] wb_line;
    logic [WAYS*LB-1:0] lines_buf;
    logic [WAYS*TB-1:0] tags_buf;
    logic [WAYS*MB-1:0] meta_buf;
    logic [WAYS-1:0] dirty_buf;
    int checks = 0, errors = 0;
    string tq[$];
    logic [127:0] eq[$];

    llc_set_buf_wb dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load),
        .rd_line(rd_line), .rd_tag(rd_tag), .rd_meta(rd_meta), .rd_dirty(rd_dirty),
        .rd_evict_way(rd_evict_way), .wr_way(wr_way),
        .wr_line_en(wr_line_en), .wr_tag_en(wr_tag_en), .wr_meta_en(wr_meta_en),
        .wr_dirty_en(wr_dirty_en), .wr_line(wr_line), .wr_tag(wr_tag), .wr_meta(wr_meta),
        .wr_dirty(wr_dirty), .evict_incr(evict_incr), .fill_start(fill_start),
        .fill_way(fill_way), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_data(fill_data), .fill_done(fill_done), .wb_start(wb_start),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_way(wb_way), .wb_tag(wb_tag),
        .wb_line(wb_line), .wb_done(wb_done), .busy(busy), .lines_buf(lines_buf),
        .tags_buf(tags_buf), .meta_buf(meta_buf), .dirty_buf(dirty_buf),
        .evict_way_buf(evict_way_buf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(input string t, input logic [127:0] v);
        tq.push_back(t);
        eq.push_back(v);
    endtask

    task automatic chk(input logic [127:0] obs);
        string t;
        logic [127:0] e;
        t = tq.size() > 0 ? tq.pop_front() : "scoreboard_empty";
        e = eq.size() > 0 ? eq.pop_front() : 128'hx;
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", t, obs, e);
        end
    endtask

    initial begin
        int cyc;
        int hs;
        // reset state
        tick(); tick();
        rst = 1'b0;
        exp("rst_ctrl", 0); chk({busy, fill_ready, wb_valid, fill_done, wb_done});
        exp("rst_bufs", 0); chk({|lines_buf, |tags_buf, |meta_buf, |dirty_buf, |evict_way_buf});
        exp("rst_wb", 0); chk({wb_way, wb_tag, |wb_line});
        // load snapshot
        rd_tag[3*TB +: TB] = 20'h1A; rd_evict_way = 4'd7; load = 1'b1;
        tick(); load = 1'b0;
        exp("load_tag3", 128'h1A); chk(tags_buf[3*TB +: TB]);
        exp("load_evict", 7); chk(evict_way_buf);
        // eviction wrap and load priority over increment
        rd_evict_way = 4'd15; load = 1'b1; tick(); load = 1'b0;
        evict_incr = 1'b1; tick();
        exp("evict_wrap", 0); chk(evict_way_buf);
        rd_evict_way = 4'd9; load = 1'b1; tick(); load = 1'b0;
        exp("evict_load_wins", 9); chk(evict_way_buf);
        tick(); evict_incr = 1'b0;
        exp("evict_incr", 10); chk(evict_way_buf);
        // fill with backpressure gaps
        fill_way = 4'd5; fill_start = 1'b1; tick(); fill_start = 1'b0;
        exp("fill_busy", 2'b11); chk({busy, fill_ready});
        tick();
        fill_valid = 1'b1; fill_data = 64'hAAAA_AAAA_AAAA_AAAA;
        wr_line_en = 1'b1; wr_way = 4'd5; wr_line = {128{1'b1}};
        tick();
        fill_valid = 1'b0; wr_line_en = 1'b0;
        exp("fill_beat0_over_wr", {64'h0, 64'hAAAA_AAAA_AAAA_AAAA}); chk(lines_buf[5*LB +: LB]);
        tick();
        exp("fill_no_done_early", 0); chk(fill_done);
        fill_valid = 1'b1; fill_data = 64'h5555_5555_5555_5555;
        wr_line_en = 1'b1; wr_way = 4'd6; wr_line = 128'h1234;
        tick();
        fill_valid = 1'b0; wr_line_en = 1'b0;
        exp("fill_done_pulse", 2'b10); chk({fill_done, busy});
        exp("fill_line5", {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA}); chk(lines_buf[5*LB +: LB]);
        exp("fill_wr_other_way", 128'h1234); chk(lines_buf[6*LB +: LB]);
        tick();
        exp("fill_done_once", 0); chk(fill_done);
        // drain with wb_ready toggling
        for (int i = 0; i < WAYS; i++) begin
            rd_tag[i*TB +: TB] = 20'h100 + TB'(i);
            rd_line[i*LB +: LB] = 128'hC0DE_0000 + 128'(i);
        end
        rd_dirty = 16'b1001_0000_0000_0100; load = 1'b1; tick(); load = 1'b0;
        exp("drain_mask", 16'h9004); chk(dirty_buf);
        wb_start = 1'b1;
        exp("drain_way", 2);  exp("drain_tag", 20'h102); exp("drain_line", 128'hC0DE_0002); exp("drain_mask_pre", 16'h9004);
        exp("drain_way", 12); exp("drain_tag", 20'h10C); exp("drain_line", 128'hC0DE_000C); exp("drain_mask_pre", 16'h9000);
        exp("drain_way", 15); exp("drain_tag", 20'h10F); exp("drain_line", 128'hC0DE_000F); exp("drain_mask_pre", 16'h8000);
        tick(); wb_start = 1'b0;
        cyc = 0; hs = 0;
        while (!wb_done && cyc < 40) begin
            wb_ready = (cyc % 2) == 1;
            if (wb_valid && wb_ready) begin
                chk(wb_way); chk(wb_tag); chk(wb_line); chk(dirty_buf);
                hs++;
            end
            tick();
            cyc++;
        end
        wb_ready = 1'b0;
        exp("drain_done", 1); chk(wb_done);
        exp("drain_handshakes", 3); chk(hs);
        exp("drain_end_state", 0); chk({busy, dirty_buf});
        tick();
        exp("drain_done_once", 0); chk(wb_done);
        // empty drain
        wb_start = 1'b1; tick(); wb_start = 1'b0;
        exp("empty_drain", 2'b01); chk({busy, wb_done});
        tick();
        exp("empty_drain_once", 0); chk({busy, wb_done});
        // start conflict: fill wins
        rd_dirty = 16'h0010; load = 1'b1; tick(); load = 1'b0;
        fill_way = 4'd1; fill_start = 1'b1; wb_start = 1'b1; tick();
        fill_start = 1'b0; wb_start = 1'b0;
        exp("conflict_fill", 3'b110); chk({busy, fill_ready, wb_valid});
        fill_valid = 1'b1; fill_data = 64'h77; tick(); tick(); fill_valid = 1'b0;
        exp("conflict_done", 3'b100); chk({fill_done, busy, wb_done});
        exp("conflict_mask_kept", 16'h0010); chk(dirty_buf);
        // clr mid-fill
        fill_way = 4'd2; fill_start = 1'b1; tick(); fill_start = 1'b0;
        fill_valid = 1'b1; fill_data = 64'h1234; tick(); fill_valid = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        exp("clr_state", 0); chk({busy, fill_ready, fill_done});
        exp("clr_bufs", 0); chk({|lines_buf, |tags_buf, |dirty_buf, |evict_way_buf});
        tick();
        exp("clr_no_done", 0); chk(fill_done);
        // async reset mid-drain
        rd_dirty = 16'h0003; load = 1'b1; tick(); load = 1'b0;
        wb_start = 1'b1; tick(); wb_start = 1'b0;
        exp("pre_rst_drain", 2'b11); chk({busy, wb_valid});
        #2 rst = 1'b1;
        #1;
        exp("async_rst", 0); chk({busy, wb_valid, wb_done, fill_ready, fill_done});
        exp("async_rst_bufs", 0); chk({wb_way, wb_tag, |wb_line, dirty_buf, |tags_buf, |lines_buf});
        tick(); rst = 1'b0; tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
